usb_packet_buffer: RTL and testbench

//  Parametrised packet FIFO between the USB packet engine (write side) and the host/AHB side (read side).

---
 rtl/usb_packet_buffer_pkg.sv | 12 +
 rtl/usb_packet_buffer_if.sv | 37 +++
 rtl/usb_packet_buffer_ram.sv | 28 ++
 rtl/usb_packet_buffer.sv | 126 ++++++++++++
 tb/tb_usb_packet_buffer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/usb_packet_buffer_pkg.sv
// Shared constants and helpers for the USB packet buffer and endpoint controller.
package usb_buf_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_DEPTH  = 64;

    // Pointer/occupancy width: one extra bit beyond the address so full and empty differ.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/usb_packet_buffer_if.sv
// Bus between the packet engine / host side (master) and the packet buffer (slave).
interface usb_packet_buffer_if
    import usb_buf_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH
) ();

    localparam int unsigned OCC_W = occ_w(DEPTH);

    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              commit;
    logic              rollback;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              flush;
    logic              clear;
    logic [OCC_W-1:0]  occupancy;
    logic [OCC_W-1:0]  pending;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_data, wr_en, commit, rollback, rd_en, flush, clear,
        input  rd_data, rd_valid, occupancy, pending, full, empty, overflow, underflow
    );

    modport slave (
        input  wr_data, wr_en, commit, rollback, rd_en, flush, clear,
        output rd_data, rd_valid, occupancy, pending, full, empty, overflow, underflow
    );

endinterface

// File: rtl/usb_packet_buffer_ram.sv
// Packet storage: one write port, one read port with registered output; storage is not reset.
module buffer_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and registered read port; rdata holds when re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/usb_packet_buffer.sv
// Packet FIFO with commit/rollback between the USB packet engine and the host side.
module usb_packet_buffer
    import usb_buf_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
    input  logic                clk,
    input  logic                n_rst,
    usb_packet_buffer_if.slave  bus
);

    localparam int unsigned OCC_W  = occ_w(DEPTH);
    localparam int unsigned ADDR_W = OCC_W - 1;

    logic [OCC_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  cm_ptr;
    logic [OCC_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  wr_ptr_nxt;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  pend;
    logic [OCC_W-1:0]  used;
    logic              is_full;
    logic              is_empty;
    logic              kill;
    logic              do_wr;
    logic              do_rd;
    logic              ovf;
    logic              unf;
    logic              rvalid;
    logic              have_data;
    logic [DATA_W-1:0] ram_q;

    // Status and per-cycle actions, all derived from registered pointers.
    always_comb begin
        occ        = cm_ptr - rd_ptr;
        pend       = wr_ptr - cm_ptr;
        used       = wr_ptr - rd_ptr;
        is_full    = (used == OCC_W'(DEPTH));
        is_empty   = (occ == '0);
        kill       = bus.flush | bus.clear;
        do_wr      = bus.wr_en & ~is_full & ~kill & ~bus.rollback;
        do_rd      = bus.rd_en & ~is_empty & ~kill;
        wr_ptr_nxt = wr_ptr + {{(OCC_W-1){1'b0}}, do_wr};
    end

    // Pointer update: flush/clear beats rollback beats write/commit/read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
            rd_ptr <= '0;
        end else if (kill) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (bus.rollback) begin
                wr_ptr <= cm_ptr;
            end else begin
                wr_ptr <= wr_ptr_nxt;
                if (bus.commit) begin
                    cm_ptr <= wr_ptr_nxt;
                end
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + {{(OCC_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Read-valid pulse and sticky error flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rvalid <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (kill) begin
            rvalid <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            rvalid <= do_rd;
            if (bus.wr_en && is_full && !bus.rollback) begin
                ovf <= 1'b1;
            end
            if (bus.rd_en && is_empty) begin
                unf <= 1'b1;
            end
        end
    end

    // The RAM output register has no reset, so rd_data is forced to zero until the
    // first successful read after reset; flush/clear leave this flag (and rd_data) alone.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            have_data <= 1'b0;
        end else if (do_rd) begin
            have_data <= 1'b1;
        end
    end

    buffer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (bus.wr_data),
        .re    (do_rd),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (ram_q)
    );

    assign bus.rd_data   = have_data ? ram_q : '0;
    assign bus.rd_valid  = rvalid;
    assign bus.occupancy = occ;
    assign bus.pending   = pend;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.overflow  = ovf;
    assign bus.underflow = unf;

endmodule

// File: tb/tb_usb_packet_buffer.sv
// Directed bench for usb_packet_buffer with a queue-based reference model and scoreboard.
module tb_usb_packet_buffer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 64;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    usb_packet_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    usb_packet_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] comm_q [$];
    logic [DW-1:0] pend_q [$];
    logic [DW-1:0] exp_q  [$];
    logic          ovf_m   = 1'b0;
    logic          unf_m   = 1'b0;
    logic [DW-1:0] last_rd = '0;
    logic [DW-1:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rd_valid pulse must carry the oldest outstanding expected word.
    always @(negedge clk) begin
        if (n_rst && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rd_valid_unexpected: observed 1 expected 0");
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", 32'(bus.rd_data), 32'(mon_exp));
            end
        end
    end

    task automatic check_status();
        check("occupancy", 32'(bus.occupancy), 32'(comm_q.size()));
        check("pending",   32'(bus.pending),   32'(pend_q.size()));
        check("full",      32'(bus.full),      32'((comm_q.size() + pend_q.size()) == DEPTH));
        check("empty",     32'(bus.empty),     32'(comm_q.size() == 0));
        check("overflow",  32'(bus.overflow),  32'(ovf_m));
        check("underflow", 32'(bus.underflow), 32'(unf_m));
    endtask

    // One clock of stimulus; the model advances on the pre-cycle state, then status is checked.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic c,
                        input logic rb, input logic r, input logic fl, input logic cl);
        logic rd_hit;
        logic full_m;
        bus.wr_en    = w;
        bus.wr_data  = d;
        bus.commit   = c;
        bus.rollback = rb;
        bus.rd_en    = r;
        bus.flush    = fl;
        bus.clear    = cl;
        @(posedge clk);
        #1;
        rd_hit = 1'b0;
        if (fl || cl) begin
            comm_q.delete();
            pend_q.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
            full_m = ((comm_q.size() + pend_q.size()) == DEPTH);
            if (r) begin
                if (comm_q.size() != 0) begin
                    last_rd = comm_q.pop_front();
                    exp_q.push_back(last_rd);
                    rd_hit = 1'b1;
                end else begin
                    unf_m = 1'b1;
                end
            end
            if (rb) begin
                pend_q.delete();
            end else begin
                if (w) begin
                    if (full_m) ovf_m = 1'b1;
                    else        pend_q.push_back(d);
                end
                if (c) begin
                    while (pend_q.size() != 0) comm_q.push_back(pend_q.pop_front());
                end
            end
        end
        bus.wr_en    = 1'b0;
        bus.commit   = 1'b0;
        bus.rollback = 1'b0;
        bus.rd_en    = 1'b0;
        bus.flush    = 1'b0;
        bus.clear    = 1'b0;
        check("rd_valid", 32'(bus.rd_valid), 32'(rd_hit));
        check_status();
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic c);
        step(1'b1, d, c, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < int'(DEPTH) && comm_q.size() != 0; i++) rd();
        idle();
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.commit = 1'b0; bus.rollback = 1'b0;
        bus.rd_en = 1'b0; bus.flush = 1'b0; bus.clear = 1'b0;

        // Reset state
        #12;
        check("reset_rd_data", 32'(bus.rd_data), 32'h0);
        check("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
        check_status();
        @(negedge clk);
        n_rst = 1'b1;

        // 1: three-word packet, committed with the last write, read back in order
        wr(8'hA1, 1'b0);
        wr(8'hA2, 1'b0);
        wr(8'hA3, 1'b1);
        check("t1_occupancy", 32'(bus.occupancy), 32'd3);
        rd(); rd(); rd();
        idle();
        check("t1_empty", 32'(bus.empty), 32'd1);

        // 2: committed words survive a rollback of a five-word packet; no stale data afterwards
        wr(8'hD0, 1'b0);
        wr(8'hD1, 1'b1);
        for (int i = 0; i < 5; i++) wr(8'hB0 + 8'(i), 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_pending", 32'(bus.pending), 32'd0);
        check("t2_occupancy", 32'(bus.occupancy), 32'd2);
        wr(8'hC0, 1'b0);
        wr(8'hC1, 1'b1);
        drain();

        // 3: fill to DEPTH, overflow on the extra write, flush clears it
        for (int i = 0; i < int'(DEPTH); i++) wr(8'(i) ^ 8'h3C, i == int'(DEPTH) - 1);
        check("t3_full", 32'(bus.full), 32'd1);
        check("t3_occupancy", 32'(bus.occupancy), 32'(DEPTH));
        wr(8'hFF, 1'b1);
        check("t3_overflow", 32'(bus.overflow), 32'd1);
        idle();
        check("t3_overflow_sticky", 32'(bus.overflow), 32'd1);
        step(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t3_flush_empty", 32'(bus.empty), 32'd1);
        check("t3_flush_rd_data_hold", 32'(bus.rd_data), 32'(last_rd));

        // 4: underflow keeps rd_data; concurrent write+commit+read at occupancy 2
        rd();
        check("t4_underflow", 32'(bus.underflow), 32'd1);
        check("t4_rd_data_hold", 32'(bus.rd_data), 32'(last_rd));
        wr(8'h41, 1'b0);
        wr(8'h42, 1'b1);
        step(1'b1, 8'h43, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t4_occupancy_stays", 32'(bus.occupancy), 32'd2);
        drain();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_clear_underflow", 32'(bus.underflow), 32'd0);

        // 5: long stream across pointer wrap, commit every 8 words, reads whenever data is committed
        for (int i = 0; i < 3 * int'(DEPTH); i++)
            step(1'b1, 8'(i) ^ 8'h5A, (i % 8) == 7, 1'b0, comm_q.size() != 0, 1'b0, 1'b0);
        drain();
        check("t5_no_overflow", 32'(bus.overflow), 32'd0);
        check("t5_no_underflow", 32'(bus.underflow), 32'd0);

        // 6: asynchronous reset mid-packet
        for (int i = 0; i < 10; i++) wr(8'h60 + 8'(i), i == 9);
        for (int i = 0; i < 4; i++) wr(8'h70 + 8'(i), 1'b0);
        rd();
        #1;
        n_rst = 1'b0;
        #1;
        comm_q.delete();
        pend_q.delete();
        exp_q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        check("t6_rd_data", 32'(bus.rd_data), 32'h0);
        check("t6_rd_valid", 32'(bus.rd_valid), 32'h0);
        check_status();
        @(negedge clk);
        n_rst = 1'b1;
        wr(8'h99, 1'b1);
        drain();

        idle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
